// File: rtl/ulpi_link_sched.sv
// Link-side ULPI bus scheduler: arbitrates packet transmit vs PHY register
// access and drives TX CMD, nxt-paced data, stp, turnaround and abort.
module ulpi_link_sched #(
  parameter int REG_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  output logic [7:0] ulpi_tx_data,
  input  logic [7:0] ulpi_rx_data,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  input  logic [7:0] tx_tdata,
  input  logic       tx_tlast,
  output logic       tx_abort,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_ack,
  output logic [7:0] reg_rdata,
  output logic       reg_err,
  output logic       busy,
  output logic [3:0] dbg_state
);

  // Handshake: a packet beat transfers on a clock edge where tx_tvalid and
  // tx_tready are both high; a register request is held until reg_ack/reg_err.

  localparam int TW = $clog2(REG_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_TXCMD   = 4'd1,
    S_TXDATA  = 4'd2,
    S_TXSTP   = 4'd3,
    S_TXDRAIN = 4'd4,
    S_RWCMD   = 4'd5,
    S_RWDATA  = 4'd6,
    S_RWSTP   = 4'd7,
    S_RRCMD   = 4'd8,
    S_RRTURN  = 4'd9,
    S_RRDATA  = 4'd10
  } state_t;

  // Interrupted ops resume through IDLE so the turnaround rule gates the retry.
  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_PKT  = 2'd1,
    R_RW   = 2'd2,
    R_RR   = 2'd3
  } resume_t;

  state_t        state, state_nx;
  resume_t       resume, resume_nx;
  logic          last_grant, last_grant_nx;  // 1 = packet path was last granted
  logic          dir_q;
  logic [TW-1:0] tmo_cnt;
  logic          start_ok, accept, reg_wait, tmo_fire, rd_done;

  assign start_ok = !ulpi_dir && !dir_q;
  assign accept   = ulpi_nxt && !ulpi_dir;
  assign reg_wait = (state == S_RWCMD || state == S_RWDATA ||
                     state == S_RRCMD || state == S_RRTURN) &&
                    !ulpi_dir && !ulpi_nxt;
  assign tmo_fire = reg_wait && (tmo_cnt == TW'(REG_TIMEOUT - 1));
  assign rd_done  = (state == S_RRDATA) && ulpi_dir && !ulpi_nxt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      resume     <= R_NONE;
      last_grant <= 1'b0;
    end else begin
      state      <= state_nx;
      resume     <= resume_nx;
      last_grant <= last_grant_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx      = state;
    resume_nx     = resume;
    last_grant_nx = last_grant;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (resume != R_NONE) begin
            resume_nx = R_NONE;
            case (resume)
              R_PKT:   state_nx = S_TXCMD;
              R_RW:    state_nx = S_RWCMD;
              default: state_nx = S_RRCMD;
            endcase
          end else if (reg_req && (!tx_tvalid || last_grant)) begin
            state_nx      = reg_we ? S_RWCMD : S_RRCMD;
            last_grant_nx = 1'b0;
          end else if (tx_tvalid) begin
            state_nx      = S_TXCMD;
            last_grant_nx = 1'b1;
          end
        end
      end
      S_TXCMD: begin
        if (ulpi_dir) begin
          state_nx  = S_IDLE;
          resume_nx = R_PKT;
        end else if (accept && tx_tvalid) begin
          state_nx = tx_tlast ? S_TXSTP : S_TXDATA;
        end
      end
      S_TXDATA: begin
        if (ulpi_dir)                          state_nx = S_TXDRAIN;
        else if (accept && tx_tvalid && tx_tlast) state_nx = S_TXSTP;
      end
      S_TXSTP:   state_nx = S_IDLE;
      S_TXDRAIN: if (tx_tvalid && tx_tlast) state_nx = S_IDLE;
      S_RWCMD, S_RWDATA: begin
        if (ulpi_dir) begin
          state_nx  = S_IDLE;
          resume_nx = R_RW;
        end else if (tmo_fire) begin
          state_nx = S_IDLE;
        end else if (accept) begin
          state_nx = (state == S_RWCMD) ? S_RWDATA : S_RWSTP;
        end
      end
      S_RWSTP: state_nx = S_IDLE;
      S_RRCMD: begin
        if (ulpi_dir) begin
          state_nx  = S_IDLE;
          resume_nx = R_RR;
        end else if (tmo_fire) begin
          state_nx = S_IDLE;
        end else if (accept) begin
          state_nx = S_RRTURN;
        end
      end
      S_RRTURN: begin
        if (ulpi_dir && ulpi_nxt) begin
          state_nx  = S_IDLE;
          resume_nx = R_RR;
        end else if (ulpi_dir) begin
          state_nx = S_RRDATA;
        end else if (tmo_fire) begin
          state_nx = S_IDLE;
        end
      end
      S_RRDATA: begin
        state_nx = S_IDLE;
        if (!rd_done) resume_nx = R_RR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ulpi_tx_data = 8'h00;
    ulpi_stp     = 1'b0;
    tx_tready    = 1'b0;
    busy         = (state != S_IDLE);
    dbg_state    = state;
    if (!ulpi_dir) begin
      case (state)
        S_TXCMD:  ulpi_tx_data = 8'h40 | {4'h0, tx_tdata[3:0]};
        S_TXDATA: ulpi_tx_data = tx_tdata;
        S_RWCMD:  ulpi_tx_data = 8'h80 | {2'b00, reg_addr};
        S_RWDATA: ulpi_tx_data = reg_wdata;
        S_RRCMD:  ulpi_tx_data = 8'hC0 | {2'b00, reg_addr};
        default:  ulpi_tx_data = 8'h00;
      endcase
      ulpi_stp = (state == S_TXSTP) || (state == S_RWSTP);
    end
    case (state)
      S_TXCMD, S_TXDATA: tx_tready = accept;
      S_TXDRAIN:         tx_tready = 1'b1;
      default:           tx_tready = 1'b0;
    endcase
  end

  // Timeout counter: counts only idle wait cycles of a register op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       tmo_cnt <= '0;
    else if (reg_wait && !tmo_fire) tmo_cnt <= tmo_cnt + 1'b1;
    else                            tmo_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q     <= 1'b0;
      reg_ack   <= 1'b0;
      reg_err   <= 1'b0;
      tx_abort  <= 1'b0;
      reg_rdata <= 8'h00;
    end else begin
      dir_q    <= ulpi_dir;
      reg_ack  <= (state == S_RWSTP) || rd_done;
      reg_err  <= tmo_fire;
      tx_abort <= (state == S_TXDATA) && ulpi_dir;
      if (rd_done) reg_rdata <= ulpi_rx_data;
    end
  end

endmodule
